// File: rtl/dbus_pkg.sv
// Shared defaults, FSM state encoding and region-index helper for the dbus_ic interconnect.
package dbus_pkg;

  localparam int unsigned DefDw = 16;
  localparam int unsigned DefAw = 16;
  localparam int unsigned DefSw = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } dbus_state_e;

  // Region index = top sw bits of an aw-bit address (address zero-extended to 32 bits).
  function automatic logic [31:0] region_of(input logic [31:0] addr, input int unsigned aw,
                                            input int unsigned sw);
    logic [31:0] mask;
    mask = (32'd1 << sw) - 32'd1;
    return (addr >> (aw - sw)) & mask;
  endfunction

endpackage

// File: rtl/dbus_dec.sv
// Combinational region decoder: address region bits to one-hot slave select plus mapped flag.
module dbus_dec import dbus_pkg::*; #(
  parameter int unsigned AW = DefAw,
  parameter int unsigned SW = DefSw,
  parameter int unsigned NS = 2
) (
  input  logic [AW-1:0] addr_i,
  output logic [SW-1:0] region_o,
  output logic [NS-1:0] onehot_o,
  output logic          mapped_o
);

  logic [31:0] region_full;

  always_comb begin
    region_full = region_of(32'(addr_i), AW, SW);
    region_o    = region_full[SW-1:0];
    onehot_o    = '0;
    mapped_o    = 1'b0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (region_full == k) begin
        onehot_o[k] = 1'b1;
        mapped_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dbus_ic.sv
// Single-master, multi-slave data-bus interconnect with req/ack handshakes and registered outputs.
// Optional slave timeout enabled by defining DBUS_TIMEOUT_EN.
module dbus_ic import dbus_pkg::*; #(
  parameter int unsigned DW     = DefDw,
  parameter int unsigned AW     = DefAw,
  parameter int unsigned SW     = DefSw,
  parameter int unsigned NS     = 2,
  parameter int unsigned TO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_req,
  input  logic             m_we,
  input  logic [AW-1:0]    m_addr,
  input  logic [DW-1:0]    m_din,
  output logic             m_ack,
  output logic             m_err,
  output logic [DW-1:0]    m_dout,
  output logic [NS-1:0]    s_req,
  output logic             s_we,
  output logic [AW-SW-1:0] s_addr,
  output logic [DW-1:0]    s_din,
  input  logic [NS-1:0]    s_ack,
  input  logic [NS*DW-1:0] s_dout
);

  dbus_state_e      state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [NS-1:0]    s_req_q, s_req_d;
  logic             s_we_q, s_we_d;
  logic [AW-SW-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0]    s_din_q, s_din_d;
  logic [DW-1:0]    m_dout_q, m_dout_d;
  logic             m_ack_q, m_ack_d;
  logic             m_err_q, m_err_d;

  logic [SW-1:0]    dec_region;
  logic [NS-1:0]    dec_onehot;
  logic             dec_mapped;
  logic [DW-1:0]    rdata;
  logic             ack_sel;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned CntW = (TO_CYC < 1) ? 1 : $clog2(TO_CYC + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`else
  logic unused_to_cyc;
  assign unused_to_cyc = ^TO_CYC;
`endif

  dbus_dec #(
    .AW(AW),
    .SW(SW),
    .NS(NS)
  ) u_dec (
    .addr_i  (m_addr),
    .region_o(dec_region),
    .onehot_o(dec_onehot),
    .mapped_o(dec_mapped)
  );

  // Only the selected slave's ack and data are visible; other slaves are ignored.
  always_comb begin
    rdata   = '0;
    ack_sel = 1'b0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (32'(sel_q) == k) begin
        rdata   = s_dout[k*DW +: DW];
        ack_sel = s_ack[k];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    s_req_d  = s_req_q;
    s_we_d   = s_we_q;
    s_addr_d = s_addr_q;
    s_din_d  = s_din_q;
    m_dout_d = m_dout_q;
    m_ack_d  = 1'b0;
    m_err_d  = 1'b0;
`ifdef DBUS_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (m_req) begin
          s_we_d   = m_we;
          s_addr_d = m_addr[AW-SW-1:0];
          s_din_d  = m_din;
          sel_d    = dec_region;
          if (dec_mapped) begin
            s_req_d = dec_onehot;
            state_d = StWait;
`ifdef DBUS_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            m_ack_d  = 1'b1;
            m_err_d  = 1'b1;
            m_dout_d = '0;
            state_d  = StResp;
          end
        end
      end
      StWait: begin
        if (ack_sel) begin
          s_req_d = '0;
          m_ack_d = 1'b1;
          state_d = StResp;
          if (!s_we_q) m_dout_d = rdata;
`ifdef DBUS_TIMEOUT_EN
        end else if (cnt_q == CntW'(TO_CYC)) begin
          s_req_d  = '0;
          m_ack_d  = 1'b1;
          m_err_d  = 1'b1;
          m_dout_d = '0;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      s_req_q  <= '0;
      s_we_q   <= 1'b0;
      s_addr_q <= '0;
      s_din_q  <= '0;
      m_dout_q <= '0;
      m_ack_q  <= 1'b0;
      m_err_q  <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      s_req_q  <= s_req_d;
      s_we_q   <= s_we_d;
      s_addr_q <= s_addr_d;
      s_din_q  <= s_din_d;
      m_dout_q <= m_dout_d;
      m_ack_q  <= m_ack_d;
      m_err_q  <= m_err_d;
`ifdef DBUS_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign m_ack  = m_ack_q;
  assign m_err  = m_err_q;
  assign m_dout = m_dout_q;
  assign s_req  = s_req_q;
  assign s_we   = s_we_q;
  assign s_addr = s_addr_q;
  assign s_din  = s_din_q;

endmodule

// File: tb/tb_dbus_ic.sv
// Bench for dbus_ic: per-transaction timeline model checked every cycle, plus literal pins.
module tb_dbus_ic;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned SW = 3;
  localparam int unsigned NS = 2;
  localparam int unsigned TO = 4;
  localparam int MaxCyc = 512;

  logic             clk = 1'b0;
  logic             rst;
  logic             m_req, m_we;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_din;
  logic             m_ack, m_err;
  logic [DW-1:0]    m_dout;
  logic [NS-1:0]    s_req;
  logic             s_we;
  logic [AW-SW-1:0] s_addr;
  logic [DW-1:0]    s_din;
  logic [NS-1:0]    s_ack;
  logic [NS*DW-1:0] s_dout;

  dbus_ic #(
    .DW(DW), .AW(AW), .SW(SW), .NS(NS), .TO_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_din(m_din),
    .m_ack(m_ack), .m_err(m_err), .m_dout(m_dout), .s_req(s_req), .s_we(s_we),
    .s_addr(s_addr), .s_din(s_din), .s_ack(s_ack), .s_dout(s_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected per-cycle timeline, filled from transaction-level rules.
  logic [NS-1:0]    e_sreq [MaxCyc];
  logic [AW-SW-1:0] e_saddr[MaxCyc];
  logic [DW-1:0]    e_din  [MaxCyc];
  logic [DW-1:0]    e_dout [MaxCyc];
  logic             e_we   [MaxCyc];
  logic             e_ack  [MaxCyc];
  logic             e_err  [MaxCyc];
  logic             e_upd  [MaxCyc];
  logic             e_rst  [MaxCyc];

  int n_chk = 0, n_pass = 0;
  bit chk_en = 1'b0;
  logic [DW-1:0] cur_dout = '0;
  int ack_cyc = -1;
  logic ack_err = 1'b0;
  int sreq0_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en && cyc < MaxCyc) begin
      if (e_rst[cyc]) begin
        cur_dout = '0;
        chk("rst_s_we", 32'(s_we), 32'd0);
        chk("rst_s_addr", 32'(s_addr), 32'd0);
        chk("rst_s_din", 32'(s_din), 32'd0);
      end
      if (e_upd[cyc]) cur_dout = e_dout[cyc];
      chk("s_req", 32'(s_req), 32'(e_sreq[cyc]));
      chk("m_ack", 32'(m_ack), 32'(e_ack[cyc]));
      chk("m_err", 32'(m_err), 32'(e_err[cyc]));
      chk("m_dout", 32'(m_dout), 32'(cur_dout));
      if (e_sreq[cyc] != '0) begin
        chk("s_addr", 32'(s_addr), 32'(e_saddr[cyc]));
        chk("s_we", 32'(s_we), 32'(e_we[cyc]));
        chk("s_din", 32'(s_din), 32'(e_din[cyc]));
      end
      if (m_ack) begin
        ack_cyc = cyc;
        ack_err = m_err;
      end
      if (s_req[0]) sreq0_cnt++;
    end
  end

  // Issue one transaction in the current (idle) cycle c0; slave acks after `waits` wait cycles.
  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] din,
                     input int waits, input logic [DW-1:0] rdata, input bit tmo,
                     input int stray, output int c0);
    int region, last, r;
    bit mapped;
    c0 = cyc;
    region = int'(addr >> (AW - SW));
    mapped = region < NS;
    if (!mapped) begin
      r = c0 + 1;
    end else begin
      last = tmo ? c0 + 1 + TO : c0 + 1 + waits;
      for (int c = c0 + 1; c <= last; c++) begin
        e_sreq[c]  = NS'(1 << region);
        e_saddr[c] = addr[AW-SW-1:0];
        e_we[c]    = we;
        e_din[c]   = din;
      end
      r = last + 1;
    end
    e_ack[r]  = 1'b1;
    e_err[r]  = !mapped || tmo;
    e_upd[r]  = !mapped || tmo || !we;
    e_dout[r] = (!mapped || tmo) ? '0 : rdata;
    m_req = 1'b1; m_we = we; m_addr = addr; m_din = din;
    while (cyc < r) begin
      @(negedge clk);
      s_ack  = '0;
      s_dout = {NS{16'hDEAD}};
      if (mapped && !tmo && cyc == c0 + 1 + waits) begin
        s_ack[region] = 1'b1;
        s_dout[region*DW +: DW] = rdata;
      end
      if (stray != 0 && cyc == c0 + stray) s_ack[1] = 1'b1;
    end
    m_req = 1'b0;
    s_ack = '0;
    @(negedge clk);
  endtask

  int c0;

  initial begin
    rst = 1'b1; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_din = '0;
    s_ack = '0; s_dout = '0;
    for (int i = 0; i < MaxCyc; i++) begin
      e_sreq[i] = '0; e_saddr[i] = '0; e_din[i] = '0; e_dout[i] = '0; e_we[i] = 1'b0;
      e_ack[i] = 1'b0; e_err[i] = 1'b0; e_upd[i] = 1'b0; e_rst[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("reset_m_ack", 32'(m_ack), 32'd0);
    chk("reset_s_req", 32'(s_req), 32'd0);
    chk("reset_m_dout", 32'(m_dout), 32'd0);
    chk("reset_s_addr", 32'(s_addr), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // Zero-wait read from slave 1.
    txn(1'b0, 16'h2005, 16'h0000, 0, 16'hBEEF, 1'b0, 0, c0);
    chk("zw_latency", 32'(ack_cyc - c0), 32'd2);
    chk("zw_dout", 32'(m_dout), 32'hBEEF);
    chk("zw_s_addr", 32'(s_addr), 32'h005);
    chk("zw_err", 32'(ack_err), 32'd0);

    // Write with 3 wait states to slave 0; read data must hold.
    sreq0_cnt = 0;
    txn(1'b1, 16'h0010, 16'h1234, 3, 16'h0BAD, 1'b0, 0, c0);
    chk("wr_latency", 32'(ack_cyc - c0), 32'd5);
    chk("wr_sreq_cycles", 32'(sreq0_cnt), 32'd4);
    chk("wr_s_din", 32'(s_din), 32'h1234);
    chk("wr_s_we", 32'(s_we), 32'd1);
    chk("wr_dout_hold", 32'(m_dout), 32'hBEEF);

    // Unmapped region 7.
    sreq0_cnt = 0;
    txn(1'b0, 16'hE000, 16'h0000, 0, 16'h0000, 1'b0, 0, c0);
    chk("um_latency", 32'(ack_cyc - c0), 32'd1);
    chk("um_err", 32'(ack_err), 32'd1);
    chk("um_dout", 32'(m_dout), 32'd0);
    chk("um_no_sreq", 32'(sreq0_cnt), 32'd0);

    // Acks while idle, then a stray slave-1 ack during a slave-0 read.
    s_ack = 2'b11;
    @(negedge clk);
    s_ack = '0;
    txn(1'b0, 16'h0007, 16'h0000, 2, 16'h5A5A, 1'b0, 1, c0);
    chk("stray_latency", 32'(ack_cyc - c0), 32'd4);
    chk("stray_dout", 32'(m_dout), 32'h5A5A);

    // Back-to-back mix.
    txn(1'b0, 16'h2100, 16'h0000, 0, 16'h1111, 1'b0, 0, c0);
    txn(1'b1, 16'h3FFF, 16'hCAFE, 1, 16'h2222, 1'b0, 0, c0);
    chk("b2b_wr_dout_hold", 32'(m_dout), 32'h1111);
    txn(1'b0, 16'h4000, 16'h0000, 0, 16'h0000, 1'b0, 0, c0);
    chk("b2b_um_err", 32'(ack_err), 32'd1);

`ifdef DBUS_TIMEOUT_EN
    sreq0_cnt = 0;
    txn(1'b0, 16'h0100, 16'h0000, 0, 16'h0000, 1'b1, 0, c0);
    chk("to_latency", 32'(ack_cyc - c0), 32'(TO + 2));
    chk("to_err", 32'(ack_err), 32'd1);
    chk("to_dout", 32'(m_dout), 32'd0);
    chk("to_sreq_cycles", 32'(sreq0_cnt), 32'(TO + 1));
    txn(1'b0, 16'h0200, 16'h0000, 1, 16'h4242, 1'b0, 0, c0);
    chk("after_to_latency", 32'(ack_cyc - c0), 32'd3);
    chk("after_to_err", 32'(ack_err), 32'd0);
`else
    txn(1'b0, 16'h0100, 16'h0000, 8, 16'h3C3C, 1'b0, 0, c0);
    chk("long_latency", 32'(ack_cyc - c0), 32'd10);
    chk("long_dout", 32'(m_dout), 32'h3C3C);
`endif

    // Reset while slave 0 stalls: abandoned without m_ack.
    c0 = cyc;
    m_req = 1'b1; m_we = 1'b0; m_addr = 16'h0040; m_din = 16'h0000;
    for (int c = c0 + 1; c <= c0 + 3; c++) begin
      e_sreq[c] = 2'b01; e_saddr[c] = 13'h040; e_we[c] = 1'b0; e_din[c] = 16'h0000;
    end
    e_rst[c0 + 4] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_req = 1'b0;
    @(negedge clk);
    chk("rstw_s_req", 32'(s_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    ack_cyc = -1;
    txn(1'b0, 16'h0001, 16'h0000, 0, 16'h7777, 1'b0, 0, c0);
    chk("rstw_latency", 32'(ack_cyc - c0), 32'd2);
    chk("rstw_dout", 32'(m_dout), 32'h7777);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
